// File: rtl/link_arb2.sv
// Two-master round-robin arbiter relaying a registered 4-phase req/ack handshake to one slave.
// Optional abort-on-no-ack watchdog is enabled by defining LINK_ARB_TIMEOUT_EN.
module link_arb2 #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [DATA_W-1:0] m0_data,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic [DATA_W-1:0] m1_data,
  output logic              m1_ack,
  output logic              s_req,
  output logic [DATA_W-1:0] s_data,
  input  logic              s_ack,
  output logic [1:0]        grant,
  output logic [7:0]        xfer_cnt,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_ACK,
    ST_WAIT_MREL,
    ST_WAIT_SREL
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_owner, w_owner_nxt;
  logic              r_last, w_last_nxt;
  logic              r_s_req, w_s_req_nxt;
  logic [DATA_W-1:0] r_s_data, w_s_data_nxt;
  logic              r_m0_ack, w_m0_ack_nxt;
  logic              r_m1_ack, w_m1_ack_nxt;
  logic [1:0]        r_grant, w_grant_nxt;
  logic [7:0]        r_xfer_cnt, w_xfer_cnt_nxt;
  logic              w_owner_req;
  logic              w_pick;

`ifdef LINK_ARB_TIMEOUT_EN
  logic [15:0]       r_tcnt, w_tcnt_nxt;
  logic              r_err, w_err_nxt;
`endif

  assign w_owner_req = r_owner ? m1_req : m0_req;
  // On a tie the master not served last wins; a lone requester always wins.
  assign w_pick      = (m0_req && m1_req) ? ~r_last : m1_req;

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_last_nxt     = r_last;
    w_s_req_nxt    = r_s_req;
    w_s_data_nxt   = r_s_data;
    w_m0_ack_nxt   = r_m0_ack;
    w_m1_ack_nxt   = r_m1_ack;
    w_grant_nxt    = r_grant;
    w_xfer_cnt_nxt = r_xfer_cnt;
`ifdef LINK_ARB_TIMEOUT_EN
    w_tcnt_nxt     = r_tcnt;
    w_err_nxt      = r_err;
`endif
    case (r_state)
      ST_IDLE: begin
        if ((m0_req || m1_req) && !s_ack) begin
          w_owner_nxt  = w_pick;
          w_s_data_nxt = w_pick ? m1_data : m0_data;
          w_grant_nxt  = w_pick ? 2'b10 : 2'b01;
          w_s_req_nxt  = 1'b1;
          w_state_nxt  = ST_WAIT_ACK;
`ifdef LINK_ARB_TIMEOUT_EN
          w_tcnt_nxt   = '0;
`endif
        end
      end
      ST_WAIT_ACK: begin
        if (s_ack) begin
          w_m0_ack_nxt = ~r_owner;
          w_m1_ack_nxt = r_owner;
          w_state_nxt  = ST_WAIT_MREL;
        end
`ifdef LINK_ARB_TIMEOUT_EN
        // Abort on the TIMEOUT-th consecutive cycle without an ack.
        else if (r_tcnt == 16'(TIMEOUT - 1)) begin
          w_s_req_nxt  = 1'b0;
          w_grant_nxt  = 2'b00;
          w_err_nxt    = 1'b1;
          w_last_nxt   = r_owner;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_tcnt_nxt   = r_tcnt + 16'd1;
        end
`endif
      end
      ST_WAIT_MREL: begin
        if (!w_owner_req) begin
          w_s_req_nxt = 1'b0;
          w_state_nxt = ST_WAIT_SREL;
        end
      end
      ST_WAIT_SREL: begin
        if (!s_ack) begin
          w_m0_ack_nxt   = 1'b0;
          w_m1_ack_nxt   = 1'b0;
          w_grant_nxt    = 2'b00;
          w_last_nxt     = r_owner;
          w_xfer_cnt_nxt = r_xfer_cnt + 8'd1;
          w_state_nxt    = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_owner    <= 1'b0;
      r_last     <= 1'b1;
      r_s_req    <= 1'b0;
      r_s_data   <= '0;
      r_m0_ack   <= 1'b0;
      r_m1_ack   <= 1'b0;
      r_grant    <= 2'b00;
      r_xfer_cnt <= '0;
`ifdef LINK_ARB_TIMEOUT_EN
      r_tcnt     <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_last     <= w_last_nxt;
      r_s_req    <= w_s_req_nxt;
      r_s_data   <= w_s_data_nxt;
      r_m0_ack   <= w_m0_ack_nxt;
      r_m1_ack   <= w_m1_ack_nxt;
      r_grant    <= w_grant_nxt;
      r_xfer_cnt <= w_xfer_cnt_nxt;
`ifdef LINK_ARB_TIMEOUT_EN
      r_tcnt     <= w_tcnt_nxt;
      r_err      <= w_err_nxt;
`endif
    end
  end

  assign m0_ack   = r_m0_ack;
  assign m1_ack   = r_m1_ack;
  assign s_req    = r_s_req;
  assign s_data   = r_s_data;
  assign grant    = r_grant;
  assign xfer_cnt = r_xfer_cnt;
`ifdef LINK_ARB_TIMEOUT_EN
  assign err      = r_err;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_link_arb2.sv
// Self-checking bench for link_arb2: transaction-level round-robin model with randomized masters/slave.
// Honours LINK_ARB_TIMEOUT_EN the same way as the design.
module tb_link_arb2;

  logic       clk = 1'b0;
  logic       rst;
  logic       m0_req, m1_req, s_ack;
  logic [7:0] m0_data, m1_data;
  logic       m0_ack, m1_ack, s_req, err;
  logic [7:0] s_data, xfer_cnt;
  logic [1:0] grant;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference state: who was served last, and completed transfer count.
  logic       m_last;
  logic [7:0] m_cnt;

  always #5 clk = ~clk;

  link_arb2 #(.DATA_W(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_data(m0_data), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_data(m1_data), .m1_ack(m1_ack),
    .s_req(s_req), .s_data(s_data), .s_ack(s_ack),
    .grant(grant), .xfer_cnt(xfer_cnt), .err(err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // An ack must never be visible to a master that does not own the grant.
  always @(negedge clk)
    check_eq("ack_owner", 32'((m0_ack && grant != 2'b01) || (m1_ack && grant != 2'b10)), 32'd0);

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0; s_ack = 1'b0;
    m0_data = '0; m1_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_last = 1'b1;
    m_cnt  = '0;
  endtask

  // One complete arbitrated transfer; masters that are already requesting keep their data.
  task automatic run_round(input logic r0, input logic r1, input logic [7:0] nd0,
                           input logic [7:0] nd1, input int unsigned lat, input bit early);
    logic       w;
    logic [7:0] exp_d;
    @(negedge clk);
    if (r0 && !m0_req) m0_data = nd0;
    if (r1 && !m1_req) m1_data = nd1;
    m0_req = r0; m1_req = r1; s_ack = 1'b0;
    w     = (r0 && r1) ? ~m_last : r1;
    exp_d = w ? m1_data : m0_data;
    @(posedge clk); #1;
    check_eq("grant", 32'(grant), w ? 32'd2 : 32'd1);
    check_eq("s_req_up", 32'(s_req), 32'd1);
    check_eq("s_data", 32'(s_data), 32'(exp_d));
    check_eq("ack_early", 32'({m1_ack, m0_ack}), 32'd0);
    @(negedge clk);
    if (early) begin
      if (w) m1_req = 1'b0; else m0_req = 1'b0;
    end
    for (int i = 0; i < int'(lat); i++) begin
      @(posedge clk); #1;
      check_eq("wait_ack", 32'({s_req, m1_ack, m0_ack}), 32'b100);
      @(negedge clk);
    end
    s_ack = 1'b1;
    @(posedge clk); #1;
    check_eq("ack_relay", 32'({m1_ack, m0_ack}), w ? 32'b10 : 32'b01);
    @(negedge clk);
    if (w) m1_req = 1'b0; else m0_req = 1'b0;
    @(posedge clk); #1;
    check_eq("s_req_down", 32'({s_req, m1_ack | m0_ack}), 32'b01);
    @(negedge clk);
    s_ack = 1'b0;
    @(posedge clk); #1;
    m_last = w;
    m_cnt  = m_cnt + 8'd1;
    check_eq("release", 32'({grant, m1_ack, m0_ack}), 32'd0);
    check_eq("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "simulation watchdog");
  end

  initial begin
    rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0; s_ack = 1'b0;
    m0_data = '0; m1_data = '0;
    do_reset();
    #1;
    check_eq("rst_outs", 32'({m0_ack, m1_ack, s_req, s_data, grant, xfer_cnt, err}), 32'd0);

    // Single master, slave acks 2 cycles after s_req
    run_round(1'b1, 1'b0, 8'hA5, 8'h00, 2, 1'b0);
    check_eq("single_data", 32'(s_data), 32'hA5);
    check_eq("single_cnt", 32'(xfer_cnt), 32'd1);

    // Tie after reset
    do_reset();
    run_round(1'b1, 1'b1, 8'h11, 8'h22, 1, 1'b0);
    check_eq("tie_first", 32'(s_data), 32'h11);
    run_round(1'b1, 1'b1, 8'h11, 8'h22, 1, 1'b0);
    check_eq("tie_second", 32'(s_data), 32'h22);
    check_eq("tie_cnt", 32'(xfer_cnt), 32'd2);

    // Fairness: both continuously requesting
    do_reset();
    for (int i = 0; i < 6; i++)
      run_round(1'b1, 1'b1, 8'($urandom), 8'($urandom), $urandom_range(0, 3), 1'b0);
    check_eq("fair_cnt", 32'(xfer_cnt), 32'd6);

    // Randomized traffic including early owner release during WAIT_ACK
    for (int i = 0; i < 40; i++) begin
      int unsigned sel;
      sel = $urandom_range(1, 3);
      run_round(sel[0] | m0_req, sel[1] | m1_req, 8'($urandom), 8'($urandom),
                $urandom_range(0, 4), ($urandom_range(0, 5) == 0));
    end

    // Counter wrap after 256 m1 transfers
    do_reset();
    for (int i = 0; i < 256; i++)
      run_round(1'b0, 1'b1, 8'h00, 8'($urandom), 0, 1'b0);
    check_eq("wrap_cnt", 32'(xfer_cnt), 32'd0);

    // Reset mid-handshake, then a stale slave ack must block new grants
    do_reset();
    @(negedge clk); m0_data = 8'h3C; m0_req = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_grant", 32'(grant), 32'd1);
    @(negedge clk); s_ack = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_ack", 32'(m0_ack), 32'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_rst", 32'({m0_ack, m1_ack, s_req, s_data, grant, xfer_cnt, err}), 32'd0);
    @(negedge clk); rst = 1'b0; m1_req = 1'b1;
    m_last = 1'b1; m_cnt = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("stale_ack", 32'({grant, s_req}), 32'd0);
    end
    @(negedge clk); m0_req = 1'b0; m1_req = 1'b0;
    run_round(1'b0, 1'b1, 8'h00, 8'h77, 1, 1'b0);
    check_eq("post_rst_data", 32'(s_data), 32'h77);

    // Slave never acks
    do_reset();
    @(negedge clk); m0_data = 8'h5A; m0_req = 1'b1;
    @(posedge clk); #1;
    check_eq("to_grant", 32'(grant), 32'd1);
    for (int i = 1; i < 16; i++) begin
      @(posedge clk); #1;
      check_eq("to_hold", 32'({s_req, err}), 32'b10);
    end
    @(posedge clk); #1;
`ifdef LINK_ARB_TIMEOUT_EN
    check_eq("to_abort", 32'({s_req, grant, m0_ack, err}), 32'b00001);
    check_eq("to_cnt", 32'(xfer_cnt), 32'd0);
    m_last = 1'b0;
    @(negedge clk); m0_req = 1'b0;
    run_round(1'b1, 1'b1, 8'h01, 8'h02, 0, 1'b0);
    check_eq("to_sticky", 32'(err), 32'd1);
`else
    check_eq("no_to_hold", 32'({s_req, grant, err}), 32'b1010);
    repeat (8) @(posedge clk);
    #1;
    check_eq("no_to_still", 32'({s_req, err}), 32'b10);
    @(negedge clk); s_ack = 1'b1;
    @(posedge clk); #1;
    check_eq("no_to_ack", 32'(m0_ack), 32'd1);
    @(negedge clk); m0_req = 1'b0;
    @(posedge clk);
    @(negedge clk); s_ack = 1'b0;
    @(posedge clk); #1;
    check_eq("no_to_cnt", 32'(xfer_cnt), 32'd1);
    check_eq("no_to_err", 32'(err), 32'd0);
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/link_arb2.md
# link_arb2

Two-master arbiter for the 4-phase req/ack link. It sits between two independent link masters and one shared link slave. It grants the slave to one master at a time using round-robin priority and relays the full 4-phase handshake, with data, through a registered path. It holds the grant until the slave's return-to-zero phase is complete.

## Interface
- DATA_W, 8, width of each master data bus and of the slave data bus
- TIMEOUT, 16, cycles to wait for `s_ack` before aborting (used only with `LINK_ARB_TIMEOUT_EN`)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- m0_req  in  1  master 0 request (4-phase level)
- m0_data  in  DATA_W  master 0 payload, stable while m0_req=1
- m0_ack  out  1  acknowledge to master 0
- m1_req  in  1  master 1 request
- m1_data  in  DATA_W  master 1 payload
- m1_ack  out  1  acknowledge to master 1
- s_req  out  1  request to shared slave
- s_data  out  DATA_W  registered payload to slave
- s_ack  in  1  slave acknowledge
- grant  out  2  one-hot current owner; 00 when idle
- xfer_cnt  out  8  completed transfers, wraps 255→0
- err  out  1  sticky timeout flag; constant 0 without `LINK_ARB_TIMEOUT_EN`

One clock; reset is synchronous and active-high. Ports are `clk` and `rst`.

## Operation
- All outputs are registered.
- Reset values:
  - m0_ack=0, m1_ack=0, s_req=0, s_data=0, grant=00, xfer_cnt=0, err=0.
  - State is IDLE.
  - The last-served pointer is 1, so m0 wins the first tie.
- **IDLE:**
  - If any mX_req=1 and s_ack=0, select a winner.
  - On a tie, the winner is the master not served last. A single requester always wins.
  - Latch mX_data into s_data, set grant, set s_req=1, and go to WAIT_ACK.
  - If s_ack=1 in IDLE (a stale slave), stay in IDLE.
- **WAIT_ACK:** when s_ack=1, set mX_ack=1 for the owner and go to WAIT_MREL.
- **WAIT_MREL:** when the owner's mX_req=0, set s_req=0 and go to WAIT_SREL.
- **WAIT_SREL:** when s_ack=0:
  - set mX_ack=0 and grant=00;
  - update the last-served pointer to the owner;
  - increment xfer_cnt (mod 256);
  - go to IDLE.
- The non-owner's ack stays 0 throughout, and its req is ignored until IDLE.
- If the owner drops req during WAIT_ACK (a protocol violation), the transfer still completes normally: WAIT_MREL exits on the first cycle it is entered.
- s_data changes only on a grant in IDLE. It holds its value between transfers.
- Reset asserted in any state forces reset values on the next edge. Masters and the slave must then return to zero by protocol; the arbiter waits in IDLE for s_ack=0.

## Timing
- Grant latency: a req sampled high in IDLE at edge N gives s_req=1 and grant valid after edge N.
- Ack relay: s_ack sampled high at edge N gives mX_ack=1 after edge N, i.e. 1 cycle of added delay per handshake edge.
- Minimum transfer with a combinational-speed slave and master: 4 arbiter edges. The next grant can occur on the edge after returning to IDLE, so back-to-back transfers are separated by 1 idle cycle.
- With both masters continuously requesting, grants alternate m0, m1, m0, and so on.

## Configuration
- `LINK_ARB_TIMEOUT_EN` defined:
  - An 8-bit-or-wider counter runs in WAIT_ACK.
  - If s_ack stays 0 for TIMEOUT consecutive cycles, the arbiter aborts:
    - set s_req=0, mX_ack=0, grant=00, err=1 (sticky until rst);
    - return to IDLE;
    - xfer_cnt is not incremented;
    - the last-served pointer is updated to the aborted owner.
- `LINK_ARB_TIMEOUT_EN` undefined: there is no counter, WAIT_ACK waits indefinitely, and err is tied to 0.

## Test plan
- **Single master:** after reset, m0_req=1 with m0_data=0xA5 and a slave acking 2 cycles after s_req → s_data=0xA5, grant=01, m0_ack rises 1 cycle after s_ack, and xfer_cnt=1 after return-to-zero.
- **Tie after reset:** m0_req and m1_req rise on the same cycle with data 0x11 and 0x22 → the first grant is 01 with s_data=0x11, then grant 10 with s_data=0x22, and xfer_cnt=2.
- **Fairness:** both masters request continuously for 6 transfers → grant sequence 01,10,01,10,01,10, m1_ack is never high while grant=01, and xfer_cnt=6.
- **Wrap:** 256 back-to-back m1 transfers → xfer_cnt returns to 0.
- **Reset mid-handshake:** rst=1 for 1 cycle while in WAIT_MREL → all outputs are at reset values on the next edge. Hold s_ack=1 afterwards → no grant until s_ack=0.
- **Timeout (macro defined, TIMEOUT=16):** m0_req=1 and the slave never acks → s_req falls and err=1 after 16 WAIT_ACK cycles, and xfer_cnt stays 0. Without the macro, s_req stays 1 and err stays 0.
